alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor to the 16-bit combinational ALU in the CPU datapath. It adds a start/busy/done handshake and registered result and flag outputs. It also adds a shift/rotate mode and iterative unsigned multiply/divide. The CPU control unit issues one operation at a time and stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, default 16: operand width (≥4, power of two).
- `SHW`, default $clog2(WIDTH): shift-amount width, taken from `b[SHW-1:0]`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: operation request, sampled only when `busy`=0.
- `a`, `b`  in  WIDTH each: operands, captured on the accepting edge.
- `mode`  in  2: 00 arith, 01 logic, 10 shift, 11 mul/div.
- `opcode`  in  3: operation within the selected mode.
- `busy`  out  1: an operation is in flight.
- `done`  out  1: one-cycle pulse; `outALU` and the flags are valid from this cycle.
- `outALU`  out  2*WIDTH: result register.
- `za`, `zb`, `eq`, `gt`, `lt`  out  1 each: registered operand flags, unsigned compare of a vs b.
- `dz`  out  1: divide by zero.
- `err`  out  1: reserved opcode.

## Operation
- Accept: `start`=1 and `busy`=0 at a rising edge. The block latches a, b, mode and opcode.
- Single-cycle results are zero-extended to 2*WIDTH unless stated otherwise.
- Mode 00 (arith):
  - 000 ADD: carry goes to bit WIDTH.
  - 001 SUB a−b: borrow goes to bit WIDTH.
  - 010 INC a, 011 DEC a: wrap in WIDTH bits, no carry.
  - 100 NEG a.
  - 101 PASS a, 110 PASS b.
  - 111 CMP: result 0, flags only.
- Mode 01 (logic): AND, OR, XOR, NAND, NOR, XNOR, NOT a, NOT b for opcodes 000–111.
- Mode 10 (shift), amount n = b[SHW-1:0]:
  - 000 SHL, 001 SHR, 010 SAR, 011 ROL, 100 ROR.
  - 101 SWAP halves of a.
  - 110/111 reserved.
- Mode 11 (iterative):
  - 000 MULU: full 2*WIDTH product, shift-add, one bit per cycle.
  - 001 DIVU: restoring division, one bit per cycle. `outALU` = {remainder, quotient}.
  - 010–111 reserved.
- Reserved opcodes: `outALU`=0, `err`=1.
- `err` and `dz` are updated on every `done` and are 0 otherwise after a `done` that clears them.
- DIVU with b=0: no iteration. `outALU` = {a, all-ones}, `dz`=1.
- Flags `za` (a==0), `zb` (b==0), `eq`, `gt`, `lt` are computed from the latched operands. They update in the `done` cycle for every operation, including reserved ones.
- FSM:
  - IDLE → EXEC on accept, for single-cycle ops, DIVU by 0 and reserved ops.
  - IDLE → ITER on accept, for MULU/DIVU.
  - ITER → EXEC after WIDTH iterations.
  - EXEC → IDLE, always, one cycle, `done`=1.
- `outALU` and all flags hold their values until the next `done`.

## Timing
- Reset: state IDLE, iteration counter 0. All outputs 0: `busy`, `done`, `outALU`, `za`, `zb`, `eq`, `gt`, `lt`, `dz`, `err`.
- Latency, counted from the accepting edge (cycle 0):
  - Single-cycle, reserved and DIV-by-zero: `done` in cycle 1.
  - MULU/DIVU: `done` in cycle WIDTH+1.
- `busy`=1 from cycle 1 up to and including the last ITER cycle. `busy`=0 in the `done` cycle.
- A `start` held high during the `done` cycle is accepted, giving back-to-back issue with no dead cycle.
- `start` while `busy`=1 is ignored, not queued.
- Operand or mode changes after acceptance have no effect on the operation in flight.
- `rst_n` low mid-operation aborts immediately and all outputs return to reset values. No `done` is produced for the aborted operation.

## Structure
- Package `alu_pkg`: mode localparams (`MODE_ARITH`, `MODE_LOGIC`, `MODE_SHIFT`, `MODE_MULDIV`), opcode localparams per mode, FSM state encoding (`S_IDLE`, `S_ITER`, `S_EXEC`).
- Sub-module `alu_muldiv_iter`:
  - Parameter `WIDTH`.
  - Inputs: `load`, `is_div`, `a`, `b`.
  - Outputs: `last`, `result`.
  - Holds the accumulator/remainder shift register and the bit counter.
- Top level: combinational single-cycle datapath, the flag compare, the FSM and the output registers.

## Test plan
- WIDTH=16, a=5, b=7:
  - ADD → `outALU`=0x0000_000C, `done` at cycle 1.
  - SUB → 0x0001_FFFE (borrow set).
  - `lt`=1, `gt`=0, `eq`=0.
- a=0x8001, b=1:
  - SAR → 0x0000_C000.
  - ROR → 0x0000_C000.
  - ROL → 0x0000_0003.
  - SHL → 0x0000_0002.
- MULU a=0xFFFF, b=0xFFFF → 0xFFFE_0001, `done` exactly at cycle 17, `busy` high for cycles 1–16. `start` pulses during `busy` are ignored.
- DIVU:
  - a=100, b=7 → 0x0002_000E.
  - a=0x1234, b=0 → 0x1234_FFFF, `dz`=1, `done` at cycle 1.
- Back-to-back: ADD issued in the `done` cycle of a MULU is accepted, with its `done` one cycle later.
- Reserved mode 11 / opcode 111 → `err`=1, `outALU`=0.
- a=0, b=0 → `za`=`zb`=`eq`=1.
- `rst_n` pulsed low at cycle 8 of a MULU → all outputs 0 and no `done`. The next MULU after release completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the sequential ALU (modes, opcodes, FSM states).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

  // Operation class selected by the 2-bit mode input
  localparam logic [1:0] MODE_ARITH  = 2'b00;
  localparam logic [1:0] MODE_LOGIC  = 2'b01;
  localparam logic [1:0] MODE_SHIFT  = 2'b10;
  localparam logic [1:0] MODE_MULDIV = 2'b11;

  // Arithmetic opcodes
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_INC   = 3'd2;
  localparam logic [2:0] OP_DEC   = 3'd3;
  localparam logic [2:0] OP_NEG   = 3'd4;
  localparam logic [2:0] OP_PASSA = 3'd5;
  localparam logic [2:0] OP_PASSB = 3'd6;
  localparam logic [2:0] OP_CMP   = 3'd7;

  // Logic opcodes
  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NAND  = 3'd3;
  localparam logic [2:0] OP_NOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_NOTA  = 3'd6;
  localparam logic [2:0] OP_NOTB  = 3'd7;

  // Shift opcodes (110/111 reserved)
  localparam logic [2:0] OP_SHL   = 3'd0;
  localparam logic [2:0] OP_SHR   = 3'd1;
  localparam logic [2:0] OP_SAR   = 3'd2;
  localparam logic [2:0] OP_ROL   = 3'd3;
  localparam logic [2:0] OP_ROR   = 3'd4;
  localparam logic [2:0] OP_SWAP  = 3'd5;

  // Iterative opcodes (010..111 reserved)
  localparam logic [2:0] OP_MULU  = 3'd0;
  localparam logic [2:0] OP_DIVU  = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_EXEC = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// Latency: WIDTH steps after load; `last` marks the step whose `result` is final.
// Backpressure: none; runs unconditionally once loaded, idles after the last step.
// Ports: clk, rst_n; load (capture a/b/is_div and start), is_div (0 MULU, 1 DIVU),
//        a, b operands; last (final step this cycle), result (value after the current step).
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  // hi: product high half / partial remainder; lo: multiplier bits / quotient bits
  logic [WIDTH-1:0] hi, lo, opnd;
  logic             div_q;
  logic             run;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] hi_n, lo_n;

  always_comb begin
    // multiply: add multiplicand into the high half when the current multiplier bit is set,
    // then shift the whole {carry, hi, lo} right by one
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // divide: shift next dividend bit into the remainder; WIDTH+1 bits so the
    // compare against the divisor sees the bit shifted out of hi
    shifted = {hi, lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    // when ge holds the difference is below 2^WIDTH, so the low bits are exact
    diff    = shifted[WIDTH-1:0] - opnd;
    if (div_q) begin
      hi_n = ge ? diff : shifted[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ge};
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end
  end

  assign result = {hi_n, lo_n};
  assign last   = run && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
      div_q <= 1'b0;
      run   <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= a;
      opnd  <= b;
      div_q <= is_div;
      run   <= 1'b1;
      cnt   <= '0;
    end else if (run) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake and registered result/flags.
// Latency: done 1 cycle after accept (single-cycle, reserved, DIVU by 0), WIDTH+1 for MULU/DIVU.
// Backpressure: start ignored (not queued) while busy; accepted in the done cycle.
// Ports: clk, rst_n; start, a, b, mode, opcode in; busy, done, outALU (2*WIDTH),
//        za/zb/eq/gt/lt (unsigned a vs b), dz (divide by zero), err (reserved opcode) out.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         mode,
  input  logic [2:0]         opcode,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] outALU,
  output logic               za,
  output logic               zb,
  output logic               eq,
  output logic               gt,
  output logic               lt,
  output logic               dz,
  output logic               err
);

  state_t state, state_n;

  logic               accept;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [SHW-1:0]     n;

  logic [WIDTH:0]     add_w, sub_w;
  logic [WIDTH-1:0]   inc_w, dec_w, neg_w, sar_w;
  logic [2*WIDTH-1:0] dbl_l, dbl_r;

  logic [2*WIDTH-1:0] sc_res;
  logic               sc_err, sc_dz, sc_iter;

  logic               it_last;
  logic [2*WIDTH-1:0] it_result;

  logic [WIDTH-1:0]   fa, fb;

  assign busy   = (state == S_ITER);
  assign done   = (state == S_EXEC);
  assign accept = start && !busy;
  assign n      = b[SHW-1:0];

  // Single-cycle datapath works on the live inputs: it is only consumed on the
  // accepting edge, where the inputs are exactly the values being latched.
  always_comb begin
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} - {1'b0, b};
    inc_w = a + WIDTH'(1);
    dec_w = a - WIDTH'(1);
    neg_w = ~a + WIDTH'(1);
    sar_w = $signed(a) >>> n;
    // rotates via a doubled copy of a: the wanted window falls in one half
    dbl_l = {a, a} << n;
    dbl_r = {a, a} >> n;
  end

  always_comb begin
    sc_res  = '0;
    sc_err  = 1'b0;
    sc_dz   = 1'b0;
    sc_iter = 1'b0;
    case (mode)
      MODE_ARITH: begin
        case (opcode)
          OP_ADD:   sc_res = {{(WIDTH-1){1'b0}}, add_w};
          OP_SUB:   sc_res = {{(WIDTH-1){1'b0}}, sub_w};
          OP_INC:   sc_res = {{WIDTH{1'b0}}, inc_w};
          OP_DEC:   sc_res = {{WIDTH{1'b0}}, dec_w};
          OP_NEG:   sc_res = {{WIDTH{1'b0}}, neg_w};
          OP_PASSA: sc_res = {{WIDTH{1'b0}}, a};
          OP_PASSB: sc_res = {{WIDTH{1'b0}}, b};
          default:  sc_res = '0;  // CMP: flags only
        endcase
      end
      MODE_LOGIC: begin
        case (opcode)
          OP_AND:  sc_res = {{WIDTH{1'b0}}, a & b};
          OP_OR:   sc_res = {{WIDTH{1'b0}}, a | b};
          OP_XOR:  sc_res = {{WIDTH{1'b0}}, a ^ b};
          OP_NAND: sc_res = {{WIDTH{1'b0}}, ~(a & b)};
          OP_NOR:  sc_res = {{WIDTH{1'b0}}, ~(a | b)};
          OP_XNOR: sc_res = {{WIDTH{1'b0}}, ~(a ^ b)};
          OP_NOTA: sc_res = {{WIDTH{1'b0}}, ~a};
          default: sc_res = {{WIDTH{1'b0}}, ~b};
        endcase
      end
      MODE_SHIFT: begin
        case (opcode)
          OP_SHL:  sc_res = {{WIDTH{1'b0}}, a << n};
          OP_SHR:  sc_res = {{WIDTH{1'b0}}, a >> n};
          OP_SAR:  sc_res = {{WIDTH{1'b0}}, sar_w};
          OP_ROL:  sc_res = {{WIDTH{1'b0}}, dbl_l[2*WIDTH-1:WIDTH]};
          OP_ROR:  sc_res = {{WIDTH{1'b0}}, dbl_r[WIDTH-1:0]};
          OP_SWAP: sc_res = {{WIDTH{1'b0}}, a[WIDTH/2-1:0], a[WIDTH-1:WIDTH/2]};
          default: sc_err = 1'b1;
        endcase
      end
      default: begin
        case (opcode)
          OP_MULU: sc_iter = 1'b1;
          OP_DIVU: begin
            // divide by zero short-circuits: no iteration, saturated quotient
            if (b == '0) begin
              sc_res = {a, {WIDTH{1'b1}}};
              sc_dz  = 1'b1;
            end else begin
              sc_iter = 1'b1;
            end
          end
          default: sc_err = 1'b1;
        endcase
      end
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept && sc_iter),
    .is_div (opcode == OP_DIVU),
    .a      (a),
    .b      (b),
    .last   (it_last),
    .result (it_result)
  );

  // EXEC behaves like IDLE for acceptance so an op issued in the done cycle
  // runs back-to-back without a dead cycle.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_EXEC: begin
        if (accept) state_n = sc_iter ? S_ITER : S_EXEC;
        else        state_n = S_IDLE;
      end
      S_ITER:  if (it_last) state_n = S_EXEC;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Flags come from the operands of the op being completed: live inputs for
  // single-cycle ops, the latched copy when an iteration finishes.
  assign fa = busy ? a_q : a;
  assign fb = busy ? b_q : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      outALU <= '0;
      err    <= 1'b0;
      dz     <= 1'b0;
      za     <= 1'b0;
      zb     <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
      lt     <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
      if ((accept && !sc_iter) || (busy && it_last)) begin
        outALU <= busy ? it_result : sc_res;
        err    <= busy ? 1'b0 : sc_err;
        dz     <= busy ? 1'b0 : sc_dz;
        za     <= (fa == '0);
        zb     <= (fb == '0);
        eq     <= (fa == fb);
        gt     <= (fa > fb);
        lt     <= (fa < fb);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=16.
// Latency: checks done-cycle position for single-cycle and iterative ops.
// Backpressure: exercises start-while-busy and back-to-back issue in the done cycle.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic [1:0]  mode;
  logic [2:0]  opcode;
  logic        busy, done;
  logic [31:0] outALU;
  logic        za, zb, eq, gt, lt, dz, err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .mode   (mode),
    .opcode (opcode),
    .busy   (busy),
    .done   (done),
    .outALU (outALU),
    .za     (za),
    .zb     (zb),
    .eq     (eq),
    .gt     (gt),
    .lt     (lt),
    .dz     (dz),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op and wait (bounded) for done; returns at the done-cycle negedge.
  task automatic issue(input logic [1:0] m, input logic [2:0] op,
                       input logic [15:0] x, input logic [15:0] y, output int lat);
    @(negedge clk);
    mode = m; opcode = op; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic vec(input string tag, input logic [1:0] m, input logic [2:0] op,
                     input logic [15:0] x, input logic [15:0] y,
                     input logic [31:0] exp_res, input logic exp_err);
    int lat;
    issue(m, op, x, y, lat);
    check({tag, "_lat"}, 64'(lat), 64'd1);
    check({tag, "_res"}, 64'(outALU), 64'(exp_res));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int done_cnt;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; mode = '0; opcode = '0;
    repeat (2) @(negedge clk);
    check("reset_out", 64'(outALU), 64'd0);
    check("reset_ctl", 64'({busy, done, za, zb, eq, gt, lt, dz, err}), 64'd0);
    rst_n = 1'b1;

    // arithmetic
    vec("add", MODE_ARITH, OP_ADD, 16'd5, 16'd7, 32'h0000_000C, 1'b0);
    check("add_flags", 64'({za, zb, eq, gt, lt}), 64'b00001);
    vec("sub", MODE_ARITH, OP_SUB, 16'd5, 16'd7, 32'h0001_FFFE, 1'b0);
    vec("add_cy", MODE_ARITH, OP_ADD, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0);
    check("gt_flags", 64'({za, zb, eq, gt, lt}), 64'b00010);
    vec("inc", MODE_ARITH, OP_INC, 16'hFFFF, 16'h0000, 32'h0000_0000, 1'b0);
    vec("dec", MODE_ARITH, OP_DEC, 16'h0000, 16'h0003, 32'h0000_FFFF, 1'b0);
    vec("neg", MODE_ARITH, OP_NEG, 16'h0001, 16'h0000, 32'h0000_FFFF, 1'b0);
    vec("passb", MODE_ARITH, OP_PASSB, 16'd5, 16'd7, 32'h0000_0007, 1'b0);
    vec("cmp", MODE_ARITH, OP_CMP, 16'd9, 16'd7, 32'h0000_0000, 1'b0);

    // logic
    vec("xor", MODE_LOGIC, OP_XOR, 16'h0F0F, 16'h00FF, 32'h0000_0FF0, 1'b0);
    vec("nand", MODE_LOGIC, OP_NAND, 16'hFFFF, 16'h00FF, 32'h0000_FF00, 1'b0);
    vec("notb", MODE_LOGIC, OP_NOTB, 16'h1234, 16'h0007, 32'h0000_FFF8, 1'b0);

    // shift / rotate
    vec("sar", MODE_SHIFT, OP_SAR, 16'h8001, 16'd1, 32'h0000_C000, 1'b0);
    vec("ror", MODE_SHIFT, OP_ROR, 16'h8001, 16'd1, 32'h0000_C000, 1'b0);
    vec("rol", MODE_SHIFT, OP_ROL, 16'h8001, 16'd1, 32'h0000_0003, 1'b0);
    vec("shl", MODE_SHIFT, OP_SHL, 16'h8001, 16'd1, 32'h0000_0002, 1'b0);
    vec("shr", MODE_SHIFT, OP_SHR, 16'h8001, 16'd1, 32'h0000_4000, 1'b0);
    vec("rol4", MODE_SHIFT, OP_ROL, 16'h8001, 16'd4, 32'h0000_0018, 1'b0);
    vec("swap", MODE_SHIFT, OP_SWAP, 16'h1234, 16'd0, 32'h0000_3412, 1'b0);
    vec("rsv_sh", MODE_SHIFT, 3'd6, 16'h1234, 16'd1, 32'h0000_0000, 1'b1);

    // zero operands
    vec("zero", MODE_ARITH, OP_ADD, 16'd0, 16'd0, 32'h0000_0000, 1'b0);
    check("zero_flags", 64'({za, zb, eq, gt, lt}), 64'b11100);

    // divide
    issue(MODE_MULDIV, OP_DIVU, 16'd100, 16'd7, lat);
    check("divu_lat", 64'(lat), 64'd17);
    check("divu_res", 64'(outALU), 64'h0002_000E);
    issue(MODE_MULDIV, OP_DIVU, 16'h1234, 16'd0, lat);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_res", 64'(outALU), 64'h1234_FFFF);
    check("div0_dz", 64'(dz), 64'd1);
    vec("after_dz", MODE_ARITH, OP_PASSA, 16'h00AA, 16'd1, 32'h0000_00AA, 1'b0);
    check("dz_clear", 64'(dz), 64'd0);
    vec("rsv_md", MODE_MULDIV, 3'd7, 16'd5, 16'd7, 32'h0000_0000, 1'b1);

    // MULU with start pulses while busy, then back-to-back ADD in the done cycle
    @(negedge clk);
    mode = MODE_MULDIV; opcode = OP_MULU; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (c == 5) begin
        start = 1'b1; mode = MODE_ARITH; opcode = OP_ADD; a = 16'd1; b = 16'd2;
      end
      if (c == 6) start = 1'b0;
      @(negedge clk);
    end
    check("mulu_busy_cycles", 64'(busy_cnt), 64'd16);
    check("mulu_early_done", 64'(done_cnt), 64'd0);
    check("mulu_done17", 64'({busy, done}), 64'b01);
    check("mulu_res", 64'(outALU), 64'hFFFE_0001);
    mode = MODE_ARITH; opcode = OP_ADD; a = 16'h0010; b = 16'h0020; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_done", 64'(done), 64'd1);
    check("b2b_res", 64'(outALU), 64'h0000_0030);
    @(negedge clk);
    check("b2b_single", 64'(done), 64'd0);

    // reset in the middle of a MULU
    @(negedge clk);
    mode = MODE_MULDIV; opcode = OP_MULU; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_out", 64'(outALU), 64'd0);
    check("arst_ctl", 64'({busy, done, za, zb, eq, gt, lt, dz, err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      done_cnt += int'(done);
    end
    check("arst_no_done", 64'(done_cnt), 64'd0);
    issue(MODE_MULDIV, OP_MULU, 16'h1234, 16'h0010, lat);
    check("mulu2_lat", 64'(lat), 64'd17);
    check("mulu2_res", 64'(outALU), 64'h0001_2340);
    check("mulu2_flags", 64'({za, zb, eq, gt, lt}), 64'b00010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
